fdau_frame_reader: RTL and testbench

Read-out side of the FDAU frame RAM. The FDAU writer fills the 512-word frame RAM once per second with ADC samples, tacho/impulse counts and ARINC words. This block reads that frame back through the RAM read port (rd_fdau / q_fdau). It serialises the frame as a sync word followed by every frame word, out of a single UART-style line (8N1, MSB byte first) towards the LPC/MCU side.

---
 rtl/fdau_pkg.sv | 12 +
 rtl/fdau_frame_reader_if.sv | 7 +
 rtl/fdau_uart_tx.sv | 46 ++++
 rtl/fdau_frame_reader.sv | 93 +++++++++
 tb/tb_fdau_frame_reader.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fdau_pkg.sv
// fdau_pkg: shared FSM encoding and frame/UART constants for the FDAU frame reader.
package fdau_pkg;
    typedef enum logic [3:0] {
        ST_IDLE, ST_SYNC_H, ST_SYNC_L, ST_FETCH, ST_WAIT_RAM,
        ST_SEND_H, ST_SEND_L, ST_NEXT, ST_DONE
    } state_t;
    localparam int          FRAME_LEN_DEF = 261;
    localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;
    localparam int          UART_BITS     = 10;
    localparam logic        START_LVL     = 1'b0;
    localparam logic        STOP_LVL      = 1'b1;
endpackage

// File: rtl/fdau_frame_reader_if.sv
// fdau_frame_reader_if: frame RAM read port; the reader is master, the RAM is slave.
interface fdau_frame_reader_if #(parameter int ADDR_W = 9);
    logic [ADDR_W-1:0] rd_fdau;
    logic [15:0]       q_fdau;
    modport master (output rd_fdau, input q_fdau);
    modport slave  (input rd_fdau, output q_fdau);
endinterface

// File: rtl/fdau_uart_tx.sv
// fdau_uart_tx: 8N1 byte serialiser, LSB first, CLK_DIV clocks per bit.
module fdau_uart_tx
    import fdau_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);
    localparam int DIV_W = $clog2(CLK_DIV);
    logic                 active, bit_end, last;
    logic [UART_BITS-1:0] shreg;
    logic [3:0]           bit_cnt;
    logic [DIV_W-1:0]     div;
    // ready in the final stop-bit cycle lets the next byte start with no gap
    always_comb begin
        bit_end    = div == DIV_W'(CLK_DIV - 1);
        last       = active && bit_end && bit_cnt == 4'(UART_BITS - 1);
        byte_ready = !active || last;
        tx         = active ? shreg[0] : STOP_LVL;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active  <= 1'b0;
            shreg   <= '1;
            bit_cnt <= '0;
            div     <= '0;
        end else if (byte_valid && byte_ready) begin
            active  <= 1'b1;
            shreg   <= {STOP_LVL, byte_data, START_LVL};
            bit_cnt <= '0;
            div     <= '0;
        end else if (active) begin
            div <= bit_end ? '0 : div + 1'b1;
            if (bit_end) begin
                active  <= !last;
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {STOP_LVL, shreg[UART_BITS-1:1]};
            end
        end
    end
endmodule

// File: rtl/fdau_frame_reader.sv
// fdau_frame_reader: reads the FDAU frame RAM and sends sync word + frame words
// over an 8N1 line, high byte first.
module fdau_frame_reader
    import fdau_pkg::*;
#(
    parameter int          FRAME_LEN = FRAME_LEN_DEF,
    parameter int          ADDR_W    = 9,
    parameter int          CLK_DIV   = 434,
    parameter int          RAM_LAT   = 1,
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    fdau_frame_reader_if.master ram,
    output logic tx,
    output logic busy,
    output logic frame_done,
    output logic overrun
);
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(FRAME_LEN - 1);
    localparam logic [1:0]      LAT       = 2'(RAM_LAT);
    state_t          state;
    logic [ADDR_W:0] word_cnt;
    logic [15:0]     holding;
    logic [1:0]      lat_cnt;
    logic            byte_valid, byte_ready, accept;
    logic [7:0]      byte_data;
    always_comb begin
        byte_valid = state inside {ST_SYNC_H, ST_SYNC_L, ST_SEND_H, ST_SEND_L};
        byte_data  = state == ST_SYNC_H ? SYNC_WORD[15:8] :
                     state == ST_SYNC_L ? SYNC_WORD[7:0]  :
                     state == ST_SEND_H ? holding[15:8]   : holding[7:0];
        accept     = byte_valid && byte_ready;
    end
    // q_fdau is sampled one cycle after the RAM_LAT window for registered RAM output
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            word_cnt    <= '0;
            holding     <= '0;
            lat_cnt     <= '0;
            ram.rd_fdau <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= start && state != ST_IDLE;
            case (state)
                ST_IDLE: if (start) begin
                    state       <= ST_SYNC_H;
                    busy        <= 1'b1;
                    ram.rd_fdau <= '0;
                    word_cnt    <= '0;
                end
                ST_SYNC_H: if (accept) state <= ST_SYNC_L;
                ST_SYNC_L: if (accept) state <= ST_FETCH;
                ST_FETCH: begin
                    ram.rd_fdau <= word_cnt[ADDR_W-1:0];
                    lat_cnt     <= '0;
                    state       <= ST_WAIT_RAM;
                end
                ST_WAIT_RAM: if (lat_cnt == LAT) begin
                    holding <= ram.q_fdau;
                    state   <= ST_SEND_H;
                end else lat_cnt <= lat_cnt + 1'b1;
                ST_SEND_H: if (accept) state <= ST_SEND_L;
                ST_SEND_L: if (accept) state <= ST_NEXT;
                ST_NEXT: if (word_cnt == LAST_WORD) state <= ST_DONE;
                else begin
                    word_cnt <= word_cnt + 1'b1;
                    state    <= ST_FETCH;
                end
                // hold until the serialiser reaches the last stop-bit cycle
                ST_DONE: if (byte_ready) begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
    fdau_uart_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .tx         (tx)
    );
endmodule

// File: tb/tb_fdau_frame_reader.sv
// tb_fdau_frame_reader: directed checks of two reader instances (short frame, 512-word frame).
module tb_fdau_frame_reader;
    typedef struct {
        logic [15:0] word;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0, start_a = 1'b0, start_b = 1'b0;
    logic tx_a, busy_a, fd_a, ov_a, tx_b, busy_b, fd_b, ov_b;
    logic [15:0] mem_a [512];
    logic [15:0] qb1;
    int tests = 0, fails = 0, cyc = 0;
    vec_t vec [3];

    always #5 clk = ~clk;

    fdau_frame_reader_if #(.ADDR_W(9)) ram_a ();
    fdau_frame_reader_if #(.ADDR_W(9)) ram_b ();

    fdau_frame_reader #(.FRAME_LEN(3), .ADDR_W(9), .CLK_DIV(4), .RAM_LAT(1), .SYNC_WORD(16'hA55A)) dut_a (
        .clock(clk), .reset(reset), .start(start_a), .ram(ram_a),
        .tx(tx_a), .busy(busy_a), .frame_done(fd_a), .overrun(ov_a));
    fdau_frame_reader #(.FRAME_LEN(512), .ADDR_W(9), .CLK_DIV(2), .RAM_LAT(2), .SYNC_WORD(16'hA55A)) dut_b (
        .clock(clk), .reset(reset), .start(start_b), .ram(ram_b),
        .tx(tx_b), .busy(busy_b), .frame_done(fd_b), .overrun(ov_b));

    // RAM models: A has one register stage, B has two and holds RAM[i]=i
    always @(posedge clk) begin
        ram_a.q_fdau <= mem_a[ram_a.rd_fdau];
        qb1          <= {7'b0, ram_b.rd_fdau};
        ram_b.q_fdau <= qb1;
    end

    int   div_l [2] = '{4, 2};
    logic tx_l [2];
    bit   rx_on [2];
    int   rx_ph [2];
    logic rx_cur [2];
    logic [9:0] rx_bits [2];
    logic [7:0] rx_q [2][$];
    int   st_q [2][$];
    int   frm_err [2];
    int   fd_hi [2];
    int   ov_hi, ov_rise, wrap_b, rd_max_b;
    logic ov_prev;
    logic [8:0] rd_last, rd_prev_b;
    logic [8:0] rd_seq [$];

    // cycle-accurate 8N1 receivers plus pulse/address monitors
    always @(negedge clk) begin
        cyc++;
        tx_l = '{tx_a, tx_b};
        for (int i = 0; i < 2; i++) begin
            if (!reset) rx_on[i] = 1'b0;
            else if (!rx_on[i]) begin
                if (tx_l[i] === 1'b0) begin
                    rx_on[i] = 1'b1;
                    rx_ph[i] = 0;
                    st_q[i].push_back(cyc);
                end
            end else rx_ph[i]++;
            if (rx_on[i]) begin
                if (rx_ph[i] % div_l[i] == 0) rx_cur[i] = tx_l[i];
                else if (tx_l[i] !== rx_cur[i]) frm_err[i]++;
                if (rx_ph[i] % div_l[i] == div_l[i] / 2) rx_bits[i][rx_ph[i] / div_l[i]] = tx_l[i];
                if (rx_ph[i] == 10 * div_l[i] - 1) begin
                    if (rx_bits[i][0] !== 1'b0 || rx_bits[i][9] !== 1'b1) frm_err[i]++;
                    rx_q[i].push_back(rx_bits[i][8:1]);
                    rx_on[i] = 1'b0;
                end
            end
        end
        if (fd_a) fd_hi[0]++;
        if (fd_b) fd_hi[1]++;
        if (ov_a) ov_hi++;
        if (ov_a && !ov_prev) ov_rise++;
        ov_prev = ov_a;
        if (ram_a.rd_fdau !== rd_last) begin
            rd_seq.push_back(ram_a.rd_fdau);
            rd_last = ram_a.rd_fdau;
        end
        if (busy_b && ram_b.rd_fdau < rd_prev_b) wrap_b++;
        if (int'(ram_b.rd_fdau) > rd_max_b) rd_max_b = int'(ram_b.rd_fdau);
        rd_prev_b = ram_b.rd_fdau;
    end

    task automatic chk_eq(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(string name, int act, int lo, int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [7:0] byte_at(int i, int k);
        return k < rx_q[i].size() ? rx_q[i][k] : 8'hxx;
    endfunction

    function automatic int bad_gaps(int i);
        int n = 0;
        for (int k = 1; k < st_q[i].size(); k++)
            if (st_q[i][k] - st_q[i][k-1] != 10 * div_l[i]) n++;
        return n;
    endfunction

    task automatic clr();
        @(negedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            rx_q[i].delete();
            st_q[i].delete();
            frm_err[i] = 0;
            fd_hi[i] = 0;
        end
        ov_hi = 0;
        ov_rise = 0;
        wrap_b = 0;
        rd_max_b = 0;
        rd_seq.delete();
        rd_last = ram_a.rd_fdau;
        rd_seq.push_back(rd_last);
    endtask

    task automatic pulse(int i);
        @(negedge clk);
        if (i == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(int i, int budget, output int n);
        n = 1;
        while (!(i == 0 ? fd_a : fd_b) && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_frame_a(string tag);
        chk_eq({tag, "_nbytes"}, rx_q[0].size(), 8);
        chk_eq({tag, "_sync_h"}, byte_at(0, 0), 8'hA5);
        chk_eq({tag, "_sync_l"}, byte_at(0, 1), 8'h5A);
        for (int k = 0; k < 3; k++) begin
            chk_eq($sformatf("%s_w%0d_hi", tag, k), byte_at(0, 2 + 2 * k), vec[k].hi);
            chk_eq($sformatf("%s_w%0d_lo", tag, k), byte_at(0, 3 + 2 * k), vec[k].lo);
        end
        chk_eq({tag, "_gaps"}, bad_gaps(0), 0);
        chk_eq({tag, "_framing"}, frm_err[0], 0);
        chk_eq({tag, "_done_width"}, fd_hi[0], 1);
        chk_eq({tag, "_busy_end"}, busy_a, 0);
    endtask

    task automatic chk_addr_seq(string tag);
        chk_eq({tag, "_addr_n"}, rd_seq.size(), 3);
        for (int k = 0; k < 3; k++)
            chk_eq($sformatf("%s_addr%0d", tag, k), k < rd_seq.size() ? rd_seq[k] : 9'h1xx, k);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        logic [15:0] w;
        logic [7:0] e;
        bit hit;
        vec[0] = '{16'h1234, 8'h12, 8'h34};
        vec[1] = '{16'hABCD, 8'hAB, 8'hCD};
        vec[2] = '{16'h0001, 8'h00, 8'h01};
        for (int k = 0; k < 512; k++) mem_a[k] = 16'h0;
        for (int k = 0; k < 3; k++) mem_a[k] = vec[k].word;

        // reset and idle
        repeat (10) @(negedge clk);
        clr();
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk_eq("rst_tx_a", tx_a, 1);
        chk_eq("rst_busy_a", busy_a, 0);
        chk_eq("rst_rd_a", ram_a.rd_fdau, 0);
        chk_eq("rst_tx_b", tx_b, 1);
        chk_eq("rst_busy_b", busy_b, 0);
        chk_eq("rst_fd_pulses", fd_hi[0] + fd_hi[1], 0);
        chk_eq("rst_ov_pulses", ov_hi, 0);

        // basic frame
        clr();
        pulse(0);
        chk_eq("basic_busy", busy_a, 1);
        wait_done(0, 400, n);
        chk_rng("basic_done_latency", n, 320, 324);
        repeat (3) @(negedge clk);
        chk_frame_a("basic");
        chk_addr_seq("basic");
        chk_eq("basic_no_overrun", ov_hi, 0);

        // start during a running frame
        clr();
        pulse(0);
        repeat (48) @(negedge clk);
        pulse(0);
        wait_done(0, 400, n);
        chk_rng("ovr_done_latency", n, 270, 276);
        repeat (3) @(negedge clk);
        chk_eq("ovr_rises", ov_rise, 1);
        chk_eq("ovr_width", ov_hi, 1);
        chk_frame_a("ovr");

        // asynchronous reset inside the third byte
        clr();
        pulse(0);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            hit = rx_q[0].size() >= 2 && tx_a === 1'b0;
        end
        chk_eq("midrst_third_byte", hit, 1);
        #2 reset = 1'b0;
        #1;
        chk_eq("midrst_tx", tx_a, 1);
        chk_eq("midrst_busy", busy_a, 0);
        chk_eq("midrst_rd", ram_a.rd_fdau, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk_eq("midrst_idle_tx", tx_a, 1);
        chk_eq("midrst_partial_bytes", rx_q[0].size(), 2);
        clr();
        pulse(0);
        wait_done(0, 400, n);
        chk_rng("resend_done_latency", n, 320, 324);
        repeat (3) @(negedge clk);
        chk_frame_a("resend");
        chk_addr_seq("resend");

        // full 512-word frame, two-cycle RAM
        clr();
        pulse(1);
        wait_done(1, 21000, n);
        chk_rng("big_done_latency", n, 20520, 20524);
        repeat (3) @(negedge clk);
        chk_eq("big_nbytes", rx_q[1].size(), 1026);
        bad = 0;
        for (int k = 0; k < rx_q[1].size(); k++) begin
            w = 16'((k - 2) / 2);
            e = k == 0 ? 8'hA5 : k == 1 ? 8'h5A : k % 2 == 0 ? w[15:8] : w[7:0];
            if (rx_q[1][k] !== e) bad++;
        end
        chk_eq("big_bad_bytes", bad, 0);
        chk_eq("big_last_hi", byte_at(1, 1024), 8'h01);
        chk_eq("big_last_lo", byte_at(1, 1025), 8'hFF);
        chk_eq("big_rd_max", rd_max_b, 511);
        chk_eq("big_rd_wrap", wrap_b, 0);
        chk_eq("big_gaps", bad_gaps(1), 0);
        chk_eq("big_framing", frm_err[1], 0);
        chk_eq("big_done_width", fd_hi[1], 1);
        chk_eq("big_busy_end", busy_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
